// File: rtl/fix_sat_sched_pkg.sv
// Shared types and helpers for the round-robin saturation scheduler.
package fix_sat_sched_pkg;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_OUT_W = 16;
    localparam int DEF_ID_W  = 2;

    // Entry layout for the default 16-bit, 4-requester configuration
    typedef struct packed {
        logic [DEF_OUT_W-1:0] data;
        logic [DEF_ID_W-1:0]  id;
        logic                 sat;
    } sat_entry_t;

endpackage

// File: rtl/fix_sat.sv
// Two's-complement width converter with clipping and a fixed-latency pipe.
module fix_sat #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16,
    parameter int SAT_PIPE  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  din,
    output logic [OUT_WIDTH-1:0] dout
);
    logic [OUT_WIDTH-1:0] sat_c;

    generate
        if (IN_WIDTH > OUT_WIDTH) begin : g_narrow
            logic [IN_WIDTH-OUT_WIDTH:0] top;
            logic                        ovf;
            assign top = din[IN_WIDTH-1:OUT_WIDTH-1];
            assign ovf = ~(&top) & (|top);
            always_comb begin
                if (ovf)
                    sat_c = din[IN_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                            : {1'b0, {(OUT_WIDTH-1){1'b1}}};
                else
                    sat_c = din[OUT_WIDTH-1:0];
            end
        end else begin : g_wide
            assign sat_c = {{(OUT_WIDTH-IN_WIDTH){din[IN_WIDTH-1]}}, din};
        end

        if (SAT_PIPE == 0) begin : g_comb
            assign dout = sat_c;
        end else begin : g_pipe
            logic [OUT_WIDTH-1:0] st [SAT_PIPE];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < SAT_PIPE; i++) st[i] <= '0;
                end else begin
                    st[0] <= sat_c;
                    for (int i = 1; i < SAT_PIPE; i++) st[i] <= st[i-1];
                end
            end
            assign dout = st[SAT_PIPE-1];
        end
    endgenerate

endmodule

// File: rtl/fix_sat_sched_rr_arb.sv
// N-way round-robin arbiter: one-hot grant searching upward from the pointer.
module rr_arb #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] ptr;

    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (en && grant == '0 && req[(int'(ptr) + k) % N]) begin
                grant[(int'(ptr) + k) % N] = 1'b1;
                idx = IW'((int'(ptr) + k) % N);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (|grant)
            ptr <= (idx == IW'(N-1)) ? '0 : idx + IW'(1);
    end

endmodule

// File: rtl/fix_sat_sched.sv
// Shares one fix_sat datapath among N_REQ requesters with a credit-guarded FIFO.
module fix_sat_sched
    import fix_sat_sched_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int SAT_PIPE   = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*IN_WIDTH-1:0]     req_data,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic [id_w(N_REQ)-1:0]        out_id,
    output logic                          out_sat,
    output logic [N_REQ*CNT_WIDTH-1:0]    sat_cnt,
    input  logic [N_REQ-1:0]              cnt_clr
);
    localparam int ID_W = id_w(N_REQ);
    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1) + 1;

    typedef struct packed {
        logic [OUT_WIDTH-1:0] data;
        logic [ID_W-1:0]      id;
        logic                 sat;
    } entry_t;

    logic [CW-1:0]        fifo_cnt, inflight;
    logic                 has_credit, issue, ovf;
    logic [N_REQ-1:0]     grant;
    logic [ID_W-1:0]      gidx;
    logic [IN_WIDTH-1:0]  sel_data;
    logic [OUT_WIDTH-1:0] sat_data;
    logic                 tail_vld, tail_sat, push, pop;
    logic [ID_W-1:0]      tail_id;
    entry_t               tail_e, head;

    // Pops only free credit on the following cycle since fifo_cnt is registered
    assign has_credit = (fifo_cnt + inflight) < CW'(FIFO_DEPTH);

    rr_arb #(.N(N_REQ), .IW(ID_W)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (has_credit & ~rst),
        .req   (req_valid),
        .grant (grant),
        .idx   (gidx)
    );

    assign req_ready = grant;
    assign issue     = |grant;
    assign sel_data  = req_data[int'(gidx)*IN_WIDTH +: IN_WIDTH];

    generate
        if (IN_WIDTH > OUT_WIDTH) begin : g_ovf
            logic [IN_WIDTH-OUT_WIDTH:0] top;
            assign top = sel_data[IN_WIDTH-1:OUT_WIDTH-1];
            assign ovf = ~(&top) & (|top);
        end else begin : g_no_ovf
            assign ovf = 1'b0;
        end
    endgenerate

    fix_sat #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SAT_PIPE  (SAT_PIPE)
    ) u_sat (
        .clk   (clk),
        .rst_n (1'b1),
        .din   (sel_data),
        .dout  (sat_data)
    );

    generate
        if (SAT_PIPE == 0) begin : g_tag_comb
            assign tail_vld = issue;
            assign tail_id  = gidx;
            assign tail_sat = ovf;
        end else begin : g_tag_pipe
            logic [SAT_PIPE-1:0] vld_q, sat_q;
            logic [ID_W-1:0]     id_q [SAT_PIPE];
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= '0;
                    sat_q <= '0;
                    for (int i = 0; i < SAT_PIPE; i++) id_q[i] <= '0;
                end else begin
                    vld_q[0] <= issue;
                    sat_q[0] <= ovf;
                    id_q[0]  <= gidx;
                    for (int i = 1; i < SAT_PIPE; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        sat_q[i] <= sat_q[i-1];
                        id_q[i]  <= id_q[i-1];
                    end
                end
            end
            assign tail_vld = vld_q[SAT_PIPE-1];
            assign tail_sat = sat_q[SAT_PIPE-1];
            assign tail_id  = id_q[SAT_PIPE-1];
        end
    endgenerate

    assign tail_e = '{data: sat_data, id: tail_id, sat: tail_sat};
    assign push   = tail_vld;

    entry_t          mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH-1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tail_e;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            inflight <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop)  rd_ptr <= nxt(rd_ptr);
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
            inflight <= inflight + CW'(issue) - CW'(push);
        end
    end

    assign head      = mem[rd_ptr];
    assign out_valid = (fifo_cnt != '0);
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? head.data : '0;
    assign out_id    = out_valid ? head.id   : '0;
    assign out_sat   = out_valid & head.sat;

    logic [CNT_WIDTH-1:0] cnt [N_REQ];

    // A clear beats a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (cnt_clr[i])
                    cnt[i] <= '0;
                else if (pop && out_sat && out_id == ID_W'(i) && ~&cnt[i])
                    cnt[i] <= cnt[i] + CNT_WIDTH'(1);
            end
        end
    end

    generate
        for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
            assign sat_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt[g];
        end
    endgenerate

endmodule

// File: tb/tb_fix_sat_sched.sv
// Scoreboard bench for fix_sat_sched: rr order, clipping, backpressure, counters.
module tb_fix_sat_sched;
    localparam int N  = 4;
    localparam int IW = 32;
    localparam int OW = 16;
    localparam int CB = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N*IW-1:0] req_data = '0;
    logic [N-1:0]  req_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] out_data;
    logic [1:0]    out_id;
    logic          out_sat;
    logic [N*CB-1:0] sat_cnt;
    logic [N-1:0]  cnt_clr = '0;

    fix_sat_sched #(
        .N_REQ(N), .IN_WIDTH(IW), .OUT_WIDTH(OW),
        .SAT_PIPE(1), .FIFO_DEPTH(4), .CNT_WIDTH(CB)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id), .out_sat(out_sat),
        .sat_cnt(sat_cnt), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        logic [1:0]  id;
        logic        sat;
    } exp_t;

    exp_t sb[$];
    int   mptr = 0;
    int   mcnt[N];

    function automatic exp_t model(input logic [31:0] x, input int id);
        exp_t e;
        e.id = 2'(id);
        if ($signed(x) > 32'sd32767) begin
            e.data = 16'h7fff; e.sat = 1'b1;
        end else if ($signed(x) < -32'sd32768) begin
            e.data = 16'h8000; e.sat = 1'b1;
        end else begin
            e.data = x[15:0]; e.sat = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [N-1:0] pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return N'(1) << ((p + k) % N);
        return '0;
    endfunction

    always @(negedge clk) begin : mon
        logic [N-1:0] eg;
        exp_t e;
        int   gi;
        logic popd;
        if (rst) begin
            check("rdy_in_rst", req_ready, 0);
            sb.delete();
            mptr = 0;
            for (int i = 0; i < N; i++) mcnt[i] = 0;
        end else begin
            eg = (sb.size() < 4) ? pick(req_valid, mptr) : '0;
            check("grant", req_ready, eg);
            for (int i = 0; i < N; i++)
                check("cnt", sat_cnt[i*CB +: CB], mcnt[i]);
            if (!out_valid)
                check("idle_out", {out_data, out_id, out_sat}, 0);
            popd = 1'b0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    popd = 1'b1;
                    check("data", out_data, e.data);
                    check("id", out_id, e.id);
                    check("sat", out_sat, e.sat);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (cnt_clr[i]) mcnt[i] = 0;
                else if (popd && e.sat && int'(e.id) == i && mcnt[i] < 3) mcnt[i]++;
            end
            if (eg != '0) begin
                gi = 0;
                for (int j = 0; j < N; j++) if (eg[j]) gi = j;
                sb.push_back(model(req_data[gi*IW +: IW], gi));
                mptr = (gi + 1) % N;
            end
        end
    end

    function automatic logic [31:0] rnd32();
        logic [31:0] b [4];
        b[0] = 32'h0000_7fff; b[1] = 32'hffff_8000;
        b[2] = 32'h0000_8000; b[3] = 32'hffff_7fff;
        case ($urandom_range(0, 2))
            0: return $urandom;
            1: return 32'(int'($urandom_range(0, 65535)) - 32768);
            default: return b[$urandom_range(0, 3)];
        endcase
    endfunction

    task automatic randomize_data();
        for (int i = 0; i < N; i++) req_data[i*IW +: IW] = rnd32();
    endtask

    task automatic send(input int i, input logic [31:0] d);
        req_valid[i] = 1'b1;
        req_data[i*IW +: IW] = d;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                @(posedge clk); #1;
                req_valid[i] = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        req_valid[i] = 1'b0;
        check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) begin
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    task automatic clear_all();
        cnt_clr = '1;
        @(posedge clk); #1;
        cnt_clr = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int g;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_outs", {out_data, out_id, out_sat}, 0);
        check("rst_cnt", sat_cnt, 0);
        check("rst_ready", req_ready, 0);

        // all requesters streaming
        @(posedge clk); #1;
        out_ready = 1'b1;
        req_valid = '1;
        randomize_data();
        @(negedge clk);
        check("rr_first", req_ready, 4'b0001);
        for (int c = 1; c < 12; c++) begin
            @(posedge clk); #1;
            randomize_data();
            @(negedge clk);
            check("rr_seq", req_ready, 64'(1) << (c % 4));
            if (c == 1) check("lat_early", out_valid, 0);
            if (c == 2) check("lat_first_id", {out_valid, out_id}, 3'b100);
            if (c >= 2) check("stream_valid", out_valid, 1);
        end
        @(posedge clk); #1;
        req_valid = '0;
        drain();

        // clipping directions and pass-through
        clear_all();
        send(2, 32'h0001_0000);
        send(2, 32'hfffe_0000);
        send(1, 32'h0000_1234);
        drain();
        @(negedge clk);
        check("cnt2_two", sat_cnt[2*CB +: CB], 2);
        check("cnt1_zero", sat_cnt[1*CB +: CB], 0);
        @(posedge clk); #1;

        // backpressure caps issue at FIFO depth
        out_ready = 1'b0;
        req_valid = '1;
        randomize_data();
        g = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (|req_ready) g++;
            @(posedge clk); #1;
        end
        check("bp_grants", g, 4);
        @(negedge clk);
        check("bp_ready", req_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        g = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (|req_ready) g++;
            @(posedge clk); #1;
        end
        check("bp_resume", g > 0, 1);
        req_valid = '0;
        drain();

        // counter saturation and clear priority
        clear_all();
        for (int k = 0; k < 5; k++) send(0, 32'h8000_0000);
        drain();
        @(negedge clk);
        check("cnt0_stick", sat_cnt[0 +: CB], 3);
        @(posedge clk); #1;
        cnt_clr[0] = 1'b1;
        @(posedge clk); #1;
        cnt_clr[0] = 1'b0;
        @(negedge clk);
        check("cnt0_clr", sat_cnt[0 +: CB], 0);
        @(posedge clk); #1;
        send(0, 32'h7fff_ffff);
        drain();
        @(negedge clk);
        check("cnt0_one", sat_cnt[0 +: CB], 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(0, 32'h4000_0000);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("wait_head", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        cnt_clr[0] = 1'b1;
        @(posedge clk); #1;
        cnt_clr[0] = 1'b0;
        @(negedge clk);
        check("clr_beats_inc", sat_cnt[0 +: CB], 0);
        @(posedge clk); #1;
        drain();

        // reset with samples in flight
        req_valid = 4'b0011;
        randomize_data();
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("post_rst_idle", out_valid, 0);
        end
        @(posedge clk); #1;
        req_valid = '1;
        @(negedge clk);
        check("ptr_restart", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        drain();
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fix_sat_sched.md
# fix_sat_sched

Round-robin scheduler sharing one `fix_sat` saturation datapath among `N_REQ` requesters. Each cycle it grants at most one valid request into the saturator, tracks the requester ID and overflow flag alongside the `SAT_PIPE`-deep datapath, and buffers results in a credit-protected output FIFO. Because the saturator pipe cannot stall, the output side can apply backpressure without losing data. Sits between per-channel producers (e.g. wide accumulators) and a shared narrow-width consumer; also keeps per-requester saturation-event counters.

## Interface
- `N_REQ`, 4, number of requesters (≥2)
- `IN_WIDTH`, 32, input sample width (two's complement)
- `OUT_WIDTH`, 16, output sample width; must differ from `IN_WIDTH`
- `SAT_PIPE`, 1, pipeline stages inside the `fix_sat` instance (≥0)
- `FIFO_DEPTH`, 4, output FIFO entries (≥1)
- `CNT_WIDTH`, 16, saturation counter width
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock, synchronous, active-high
- `req_valid`  in  N_REQ  request valid per requester
- `req_data`  in  N_REQ*IN_WIDTH  sample per requester; requester i at [i*IN_WIDTH +: IN_WIDTH]
- `req_ready`  out  N_REQ  one-hot grant; a transfer occurs when valid and ready are both high
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  consumer accepts head
- `out_data`  out  OUT_WIDTH  saturated sample
- `out_id`  out  $clog2(N_REQ)  originating requester
- `out_sat`  out  1  sample was clipped
- `sat_cnt`  out  N_REQ*CNT_WIDTH  per-requester clip counts
- `cnt_clr`  in  N_REQ  per-requester counter clear

## Operation
- Credit: `credit = FIFO_DEPTH - fifo_count - inflight`. `inflight` counts issued samples not yet written to the FIFO. A pop in the current cycle does not add credit until the next cycle.
- Issue: when `credit > 0` and any `req_valid` is high, grant the first valid requester at or after `rr_ptr`, searching upward with wrap. `req_ready` is the grant and is combinational from `req_valid`. With no credit, `req_ready` is 0.
- On grant g, `rr_ptr` becomes `(g+1) mod N_REQ`. The pointer holds when there is no grant.
- Datapath: the granted `req_data` slice is muxed into `fix_sat`. The ID and a valid bit travel in a `SAT_PIPE`-stage shift register that runs in parallel and has reset.
- Overflow flag: computed at issue and carried with the ID.
  - `IN_WIDTH > OUT_WIDTH`: bits [IN_WIDTH-1 : OUT_WIDTH-1] are not all-equal.
  - `OUT_WIDTH > IN_WIDTH`: the flag is always 0.
- Clip values: positive overflow gives 0x7FFF; negative overflow gives 0x8000 (OUT_WIDTH=16).
- FIFO: the tail of the shift register writes {data, id, sat} into the FIFO. Pop occurs on `out_valid & out_ready`. Simultaneous push and pop on a full FIFO is legal; a full FIFO is never pushed by construction.
- Counters: on a pop with `out_sat=1`, `sat_cnt[out_id]` increments and sticks at all-ones. If `cnt_clr[i]` coincides with an increment of counter i, the clear wins and the counter becomes 0.
- `rst`: clears FIFO, shift valid bits, `inflight`, `rr_ptr`=0 and all counters. Data in flight at reset is discarded. Datapath data registers need no reset.

## Timing
- During and after reset: `req_ready`=0 while `rst` is high; `out_valid`=0, `out_data`=0, `out_id`=0, `out_sat`=0, `sat_cnt`=0.
- Grant in cycle t → `out_valid` in cycle t+SAT_PIPE+1. With `SAT_PIPE=0`, the FIFO is written at the end of t and `out_valid` rises at t+1.
- Sustained one grant per cycle requires `FIFO_DEPTH ≥ SAT_PIPE+2` with `out_ready` held high. Smaller depths throttle issue but never drop data.
- The counter update is visible on `sat_cnt` the cycle after the pop.

## Structure
- Package `fix_sat_sched_pkg` holds:
  - the `ID_W = $clog2(N_REQ)` helper function;
  - a packed struct `sat_entry_t` {data, id, sat} used for the FIFO entry and the shift-register tail.
- Existing `fix_sat` is instantiated with `SAT_PIPE` and its `rst_n` tied to 1. Validity is tracked only in this block.
- One natural sub-module: `rr_arb`, a parameterised N-way round-robin arbiter with pointer and one-hot grant.
- FIFO and credit logic stay inline.

## Test plan
- Reset then idle, with N_REQ=4, IN=32, OUT=16, SAT_PIPE=1, FIFO_DEPTH=4 → all outputs 0; `req_ready`=0 while `rst` high.
- All four valid every cycle, `out_ready`=1 → grants cycle 0,1,2,3,0…; one output per cycle from t+2; `out_id` sequence 0,1,2,3,0.
- Requester 2 sends 0x0001_0000 and 0xFFFE_0000; requester 1 sends 0x0000_1234 → outputs 0x7FFF sat=1, 0x8000 sat=1, 0x1234 sat=0; `sat_cnt[2]`=2, `sat_cnt[1]`=0.
- `out_ready`=0 with continuous requests → exactly 4 grants then `req_ready`=0; on release, 4 entries drain in order and issue resumes.
- With CNT_WIDTH=2 → 5 clipped samples leave the counter at 3. `cnt_clr` asserted on the same cycle as a clipped pop → counter 0.
- Assert `rst` with 2 samples in flight → no `out_valid` after reset; `rr_ptr` restarts at 0.
